// File: rtl/div_share_arbiter.sv
// Purpose : shares one signed long-division unit among NUM_REQ requesters, round-robin.
// Latency : accept at T, divider cleared at T+1, VALID from T+2; response one state after capture (D==0: T+1).
// Backpres: one job in flight; requesters hold req_valid until their one-cycle req_ready pulse.
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   req_valid_i/req_n_i/req_d_i  per-requester request and packed operands (slice i = [i*WIDTH +: WIDTH])
//   req_ready_o                one-hot accept pulse
//   rsp_valid_o                one-hot response pulse; rsp_q_o/rsp_r_o/rsp_dz_o/rsp_to_o qualified by it
//   div_*                      handshake and operands toward the shared divider
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 48
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_n_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_d_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]         rsp_q_o,
    output logic [WIDTH-1:0]         rsp_r_o,
    output logic                     rsp_dz_o,
    output logic                     rsp_to_o,
    output logic                     div_reset_o,
    output logic                     div_valid_o,
    output logic [WIDTH-1:0]         div_n_o,
    output logic [WIDTH-1:0]         div_d_o,
    input  logic                     div_ready_i,
    input  logic [WIDTH-1:0]         div_q_i,
    input  logic [WIDTH-2:0]         div_r_i,
    input  logic                     div_dz_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_RESP
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rr_q;
    logic [IDX_W-1:0]     owner_q;
    logic [WD_W-1:0]      wd_q;
    logic [WD_W-1:0]      wd_d;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     rem_q;
    logic                 rsp_dz_q;
    logic                 rsp_to_q;
    logic                 div_reset_q;
    logic                 div_valid_q;
    logic [WIDTH-1:0]     div_n_q;
    logic [WIDTH-1:0]     div_d_q;

    // Round-robin pick: first requester after the last winner, wrapping.
    logic                 gnt_vld;
    logic [IDX_W-1:0]     gnt_idx;
    logic [WIDTH-1:0]     gnt_n;
    logic [WIDTH-1:0]     gnt_d;
    int                   cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_n   = '0;
        gnt_d   = '0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_q) + k) % NUM_REQ;
            if (!gnt_vld && req_valid_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(cand);
                gnt_n   = req_n_i[cand*WIDTH +: WIDTH];
                gnt_d   = req_d_i[cand*WIDTH +: WIDTH];
            end
        end
    end

    assign wd_d = wd_q + WD_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            rr_q        <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            wd_q        <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            rsp_dz_q    <= 1'b0;
            rsp_to_q    <= 1'b0;
            div_reset_q <= 1'b1;
            div_valid_q <= 1'b0;
            div_n_q     <= '0;
            div_d_q     <= '0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    // Divider is held cleared while nothing is running.
                    div_reset_q <= 1'b1;
                    div_valid_q <= 1'b0;
                    if (gnt_vld) begin
                        req_ready_q[gnt_idx] <= 1'b1;
                        owner_q  <= gnt_idx;
                        rr_q     <= gnt_idx;
                        div_n_q  <= gnt_n;
                        div_d_q  <= gnt_d;
                        quo_q    <= '0;
                        rem_q    <= '0;
                        rsp_to_q <= 1'b0;
                        // Zero divisor never reaches the divider.
                        rsp_dz_q <= (gnt_d == '0);
                        state_q  <= (gnt_d == '0) ? S_RESP : S_CLR;
                    end
                end
                S_CLR: begin
                    div_reset_q <= 1'b1;
                    div_valid_q <= 1'b0;
                    wd_q        <= '0;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    div_reset_q <= 1'b0;
                    div_valid_q <= 1'b1;
                    wd_q        <= wd_d;
                    // A real result beats the watchdog when both land together.
                    if (div_ready_i || div_dz_i) begin
                        quo_q    <= div_q_i;
                        rem_q    <= {1'b0, div_r_i};
                        rsp_dz_q <= div_dz_i;
                        rsp_to_q <= 1'b0;
                        state_q  <= S_RESP;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        quo_q    <= '0;
                        rem_q    <= '0;
                        rsp_dz_q <= 1'b0;
                        rsp_to_q <= 1'b1;
                        state_q  <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_q[owner_q] <= 1'b1;
                    div_valid_q <= 1'b0;
                    div_reset_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_q_o     = quo_q;
    assign rsp_r_o     = rem_q;
    assign rsp_dz_o    = rsp_dz_q;
    assign rsp_to_o    = rsp_to_q;
    assign div_reset_o = div_reset_q;
    assign div_valid_o = div_valid_q;
    assign div_n_o     = div_n_q;
    assign div_d_o     = div_d_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Purpose : directed bench for div_share_arbiter with a behavioural divider stand-in.
// Latency : divider answers a fixed number of cycles after VALID, or never when hung.
// Backpres: requests are held until the accept pulse, then dropped.
module tb_div_share_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 48;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_n;
    logic [NR*W-1:0]   req_d;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [W-1:0]      rsp_q;
    logic [W-1:0]      rsp_r;
    logic              rsp_dz;
    logic              rsp_to;
    logic              div_reset;
    logic              div_valid;
    logic [W-1:0]      div_n;
    logic [W-1:0]      div_d;
    logic              div_ready;
    logic [W-1:0]      div_q;
    logic [W-2:0]      div_r;
    logic              div_dz;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 4;
    bit hang    = 1'b0;
    int dcnt;

    always #5 clk = ~clk;

    div_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_n_i(req_n), .req_d_i(req_d),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
        .rsp_q_o(rsp_q), .rsp_r_o(rsp_r), .rsp_dz_o(rsp_dz), .rsp_to_o(rsp_to),
        .div_reset_o(div_reset), .div_valid_o(div_valid),
        .div_n_o(div_n), .div_d_o(div_d),
        .div_ready_i(div_ready), .div_q_i(div_q), .div_r_i(div_r), .div_dz_i(div_dz)
    );

    // Euclidean signed division: remainder always non-negative.
    function automatic logic [63:0] euclid(input logic [31:0] n, input logic [31:0] d);
        longint sn, sd, q, r;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        if (sd == 0) return 64'd0;
        q = sn / sd;
        r = sn - q * sd;
        if (r < 0) begin
            if (sd > 0) begin q = q - 1; r = r + sd; end
            else        begin q = q + 1; r = r - sd; end
        end
        return {q[31:0], r[31:0]};
    endfunction

    logic [63:0] div_res;
    assign div_res = euclid(div_n, div_d);
    assign div_dz  = 1'b0;

    always @(posedge clk) begin
        if (div_reset) begin
            dcnt      <= 0;
            div_ready <= 1'b0;
            div_q     <= '0;
            div_r     <= '0;
        end else if (div_valid && !hang && !div_ready) begin
            if (dcnt == lat - 1) begin
                div_ready <= 1'b1;
                div_q     <= div_res[63:32];
                div_r     <= div_res[W-2:0];
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        to;
        string       tag;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no event expected one within bound", name);
    endtask

    task automatic set_req(input int i, input logic [31:0] n, input logic [31:0] d);
        req_valid[i]       = 1'b1;
        req_n[i*W +: W]    = n;
        req_d[i*W +: W]    = d;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin ok = 1'b1; return; end
        end
    endtask

    // One request from accept to response; dv_to_rsp counts cycles from first VALID to response.
    task automatic run_op(input int idx, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] q, input logic [31:0] r, input logic dz,
                          input logic to, input string tag, output int dv_to_rsp);
        bit           ok;
        bit           got;
        bit           dv_seen;
        int           dv_first;
        int           kk;
        logic [NR-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        dv_seen  = 1'b0;
        dv_first = 0;
        dv_to_rsp = -1;
        got = 1'b0;
        kk  = 0;
        set_req(idx, n, d);
        wait_ready(ok);
        if (!ok) begin
            bound_fail({tag, " ready"});
            req_valid = '0;
            return;
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'(oh));
        req_valid[idx] = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, " div_reset T+1"}, 32'(div_reset), 32'd1);
                chk({tag, " div_n latched"}, div_n, n);
                chk({tag, " div_d latched"}, div_d, d);
            end
            if (k == 2 && !dz) chk({tag, " div_valid T+2"}, 32'(div_valid), 32'd1);
            if (div_valid && !dv_seen) begin dv_seen = 1'b1; dv_first = k; end
            if (rsp_valid != '0) begin got = 1'b1; kk = k; break; end
        end
        if (!got) begin
            bound_fail({tag, " rsp"});
            return;
        end
        if (dz) begin
            chk({tag, " dz latency"}, 32'(kk), 32'd1);
            chk({tag, " div_valid never"}, 32'(dv_seen), 32'd0);
        end
        dv_to_rsp = kk - dv_first;
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, " q"}, rsp_q, q);
        chk({tag, " r"}, rsp_r, r);
        chk({tag, " dz"}, 32'(rsp_dz), 32'(dz));
        chk({tag, " to"}, 32'(rsp_to), 32'(to));
        @(negedge clk);
        chk({tag, " rsp pulse end"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit ok;
        int dvr;
        int cnt;

        tv[0] = '{0, 32'd27,        32'd5,        32'd5,        32'd2, 1'b0, 1'b0, "pos"};
        tv[1] = '{1, 32'hFFFFFFE5,  32'd5,        32'hFFFFFFFA, 32'd3, 1'b0, 1'b0, "negn"};
        tv[2] = '{2, 32'd27,        32'hFFFFFFFB, 32'hFFFFFFFB, 32'd2, 1'b0, 1'b0, "negd"};
        tv[3] = '{3, 32'h11111111,  32'd0,        32'd0,        32'd0, 1'b1, 1'b0, "dzero"};
        tv[4] = '{1, 32'd100,       32'd7,        32'd14,       32'd2, 1'b0, 1'b0, "misc"};

        reset     = 1'b1;
        req_valid = '0;
        req_n     = '0;
        req_d     = '0;
        repeat (3) @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_q", rsp_q, 32'd0);
        chk("rst rsp_r", rsp_r, 32'd0);
        chk("rst rsp_dz", 32'(rsp_dz), 32'd0);
        chk("rst rsp_to", 32'(rsp_to), 32'd0);
        chk("rst div_valid", 32'(div_valid), 32'd0);
        chk("rst div_reset", 32'(div_reset), 32'd1);
        chk("rst div_n", div_n, 32'd0);
        chk("rst div_d", div_d, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_op(tv[i].idx, tv[i].n, tv[i].d, tv[i].q, tv[i].r, tv[i].dz, tv[i].to, tv[i].tag, dvr);

        // Fresh round-robin pointer, everyone requesting continuously.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 32'd50, 32'd2);
        for (int g = 0; g < 5; g++) begin
            logic [NR-1:0] oh;
            oh = '0;
            oh[g % NR] = 1'b1;
            wait_ready(ok);
            if (!ok) begin bound_fail("rr ready"); break; end
            chk("rr grant", 32'(req_ready), 32'(oh));
            if (g == 4) req_valid = '0;
            wait_rsp(ok);
            if (!ok) begin bound_fail("rr rsp"); break; end
            chk("rr rsp_valid", 32'(rsp_valid), 32'(oh));
            chk("rr q", rsp_q, 32'd25);
            chk("rr r", rsp_r, 32'd0);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);

        // Hung divider: watchdog fires TIMEOUT cycles after VALID rises.
        hang = 1'b1;
        run_op(2, 32'd51, 32'd2, 32'd0, 32'd0, 1'b0, 1'b1, "timeout", dvr);
        chk("timeout cycles", 32'(dvr), 32'(TO));
        hang = 1'b0;
        run_op(2, 32'd51, 32'd2, 32'd25, 32'd1, 1'b0, 1'b0, "after_to", dvr);

        // Reset in the middle of RUN drops the job and rewinds the pointer.
        lat = 20;
        set_req(1, 32'd100, 32'd3);
        wait_ready(ok);
        if (!ok) bound_fail("abort ready");
        req_valid = '0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (div_valid) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("abort div_valid");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort div_reset", 32'(div_reset), 32'd1);
        chk("abort div_valid", 32'(div_valid), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd0);
        chk("abort rsp_q", rsp_q, 32'd0);
        chk("abort rsp_to", 32'(rsp_to), 32'd0);
        chk("abort div_n", div_n, 32'd0);
        chk("abort div_d", div_d, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lat = 4;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) cnt++;
        end
        chk("abort no rsp", 32'(cnt), 32'd0);
        set_req(0, 32'd9, 32'd4);
        set_req(2, 32'd9, 32'd4);
        wait_ready(ok);
        if (!ok) bound_fail("post-reset ready");
        else chk("post-reset grant", 32'(req_ready), 32'd1);
        req_valid = '0;
        wait_rsp(ok);
        if (!ok) bound_fail("post-reset rsp");
        else begin
            chk("post-reset rsp_valid", 32'(rsp_valid), 32'd1);
            chk("post-reset q", rsp_q, 32'd2);
            chk("post-reset r", rsp_r, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
